// File: rtl/tomasulo_pkg.sv
// Shared definitions for the tomasulo core and its trace recorder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tomasulo_pkg;

    // Stage select used by the trace read port
    typedef logic [2:0] stage_sel_t;

    localparam stage_sel_t STAGE_ISSUE    = 3'd0;
    localparam stage_sel_t STAGE_EX_START = 3'd1;
    localparam stage_sel_t STAGE_EX_COMP  = 3'd2;
    localparam stage_sel_t STAGE_WRITE    = 3'd3;
    localparam stage_sel_t STAGE_COMMIT   = 3'd4;
    localparam int         NUM_STAGES     = 5;

    // Opcodes and functional-unit latencies shared with the core
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_SD  = 3'd5;

    localparam int LAT_ADD = 2;
    localparam int LAT_MUL = 10;
    localparam int LAT_DIV = 40;
    localparam int LAT_LD  = 2;

    // Recorder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } trace_state_t;

endpackage

// File: rtl/tomasulo_stage_capture.sv
// One stage column of the timing table: rising detect, write-once stamps, recorded flags.
// Latency: stamp and flag visible one edge after the capturing edge.
// Backpressure: none; capture is gated purely by the capture enable.
module tomasulo_stage_capture #(
    parameter int NUM_INSTRUCTIONS = 31,
    parameter int CYCLE_WIDTH      = 9
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          capture,
    input  logic [NUM_INSTRUCTIONS-1:0]                   status,
    input  logic [CYCLE_WIDTH-1:0]                        stamp_value,
    output logic [NUM_INSTRUCTIONS-1:0][CYCLE_WIDTH-1:0]  stamps,
    output logic [NUM_INSTRUCTIONS-1:0]                   recorded,
    output logic [NUM_INSTRUCTIONS-1:0]                   recorded_next
);

    logic [NUM_INSTRUCTIONS-1:0] prev;
    logic [NUM_INSTRUCTIONS-1:0] rise;

    // Rising edges seen on a capture edge; falls and held-high bits are ignored
    always_comb begin
        rise          = capture ? (status & ~prev) : '0;
        recorded_next = recorded | rise;
    end

    // Stamp first rise only; a re-rise of an already recorded bit leaves the stamp alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            recorded <= '0;
            stamps   <= '0;
        end else if (capture) begin
            prev     <= status;
            recorded <= recorded_next;
            for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
                if (rise[i] && !recorded[i]) begin
                    stamps[i] <= stamp_value;
                end
            end
        end
    end

endmodule

// File: rtl/tomasulo_trace_recorder.sv
// Records first-rise cycle stamps of the core's per-instruction status vectors; optional order checker under TOMASULO_TRACE_CHECK_EN.
// Latency: captures on the edge a bit rises; read data one cycle after rd_req.
// Backpressure: none; reads are always accepted, capture pauses while run is low.
module tomasulo_trace_recorder
    import tomasulo_pkg::*;
#(
    parameter int NUM_INSTRUCTIONS = 31,
    parameter int NUM_CYCLES       = 500,
    parameter int CYCLE_WIDTH      = $clog2(NUM_CYCLES),
    parameter int IDX_WIDTH        = $clog2(NUM_INSTRUCTIONS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [IDX_WIDTH:0]           num_valid,
    input  logic [NUM_INSTRUCTIONS-1:0]  issue,
    input  logic [NUM_INSTRUCTIONS-1:0]  ex_start,
    input  logic [NUM_INSTRUCTIONS-1:0]  ex_comp,
    input  logic [NUM_INSTRUCTIONS-1:0]  write,
    input  logic [NUM_INSTRUCTIONS-1:0]  commit,
    input  logic                         rd_req,
    input  logic [IDX_WIDTH-1:0]         rd_idx,
    input  logic [2:0]                   rd_stage,
    output logic                         rd_valid,
    output logic [CYCLE_WIDTH-1:0]       rd_data,
    output logic                         rd_recorded,
    output logic [CYCLE_WIDTH-1:0]       cycle_count,
    output logic                         all_done,
    output logic                         overflow,
    output logic                         order_error
);

    localparam int                     NVW       = IDX_WIDTH + 1;
    localparam logic [CYCLE_WIDTH-1:0] COUNT_MAX = CYCLE_WIDTH'(NUM_CYCLES - 1);

    trace_state_t state, state_next;
    logic         capture;
    logic         done_now;

    logic [NUM_STAGES-1:0][NUM_INSTRUCTIONS-1:0]                  stage_in;
    logic [NUM_STAGES-1:0][NUM_INSTRUCTIONS-1:0][CYCLE_WIDTH-1:0] stamp_all;
    logic [NUM_STAGES-1:0][NUM_INSTRUCTIONS-1:0]                  rec_all;
    logic [NUM_STAGES-1:0][NUM_INSTRUCTIONS-1:0]                  rec_next_all;

    assign stage_in[STAGE_ISSUE]    = issue;
    assign stage_in[STAGE_EX_START] = ex_start;
    assign stage_in[STAGE_EX_COMP]  = ex_comp;
    assign stage_in[STAGE_WRITE]    = write;
    assign stage_in[STAGE_COMMIT]   = commit;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        tomasulo_stage_capture #(
            .NUM_INSTRUCTIONS (NUM_INSTRUCTIONS),
            .CYCLE_WIDTH      (CYCLE_WIDTH)
        ) u_capture (
            .clk           (clk),
            .reset         (reset),
            .capture       (capture),
            .status        (stage_in[s]),
            .stamp_value   (cycle_count),
            .stamps        (stamp_all[s]),
            .recorded      (rec_all[s]),
            .recorded_next (rec_next_all[s])
        );
    end

    // Completion test on the post-capture commit flags so all_done lands with the final commit
    always_comb begin
        done_now = capture && (num_valid != '0);
        for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
            if ((NVW'(i) < num_valid) && !rec_next_all[STAGE_COMMIT][i]) begin
                done_now = 1'b0;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and capture enable; DONE freezes everything until reset
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                capture = run;
                if (run) begin
                    state_next = done_now ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                capture = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Cycle counter with saturation, sticky overflow and sticky completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            overflow    <= 1'b0;
            all_done    <= 1'b0;
        end else if (capture) begin
            if (cycle_count == COUNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (done_now) begin
                all_done <= 1'b1;
            end
        end
    end

    // Registered read port; out-of-range selects return an empty entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_recorded <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (({1'b0, rd_idx} >= NVW'(NUM_INSTRUCTIONS)) || (rd_stage > STAGE_COMMIT)) begin
                    rd_data     <= '0;
                    rd_recorded <= 1'b0;
                end else begin
                    rd_data     <= stamp_all[rd_stage][rd_idx];
                    rd_recorded <= rec_all[rd_stage][rd_idx];
                end
            end
        end
    end

`ifdef TOMASULO_TRACE_CHECK_EN
    logic [NUM_STAGES-1:0] stage_err;
    logic                  commit_err;

    assign stage_err[0] = 1'b0;
    for (genvar s = 1; s < NUM_STAGES; s++) begin : g_order
        // A stage newly recorded while its predecessor is still unrecorded after this edge
        assign stage_err[s] = |((rec_next_all[s] & ~rec_all[s]) & ~rec_next_all[s-1]);
    end

    // Commits must retire in program order
    assign commit_err = |((rec_next_all[STAGE_COMMIT][NUM_INSTRUCTIONS-1:1]
                           & ~rec_all[STAGE_COMMIT][NUM_INSTRUCTIONS-1:1])
                          & ~rec_next_all[STAGE_COMMIT][NUM_INSTRUCTIONS-2:0]);

    // Sticky ordering violation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_error <= 1'b0;
        end else if (capture && ((|stage_err) || commit_err)) begin
            order_error <= 1'b1;
        end
    end
`else
    assign order_error = 1'b0;
`endif

endmodule

// File: tb/tb_tomasulo_trace_recorder.sv
// Self-checking bench for tomasulo_trace_recorder with a read-response scoreboard.
// Latency: expects read responses exactly one cycle after each request.
// Backpressure: none exercised; reads may be issued back to back.
module tb_tomasulo_trace_recorder;

    localparam int N   = 31;
    localparam int NC  = 16;
    localparam int CW  = $clog2(NC);
    localparam int IW  = $clog2(N);

    typedef struct packed {
        logic [CW-1:0] data;
        logic          rec;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [IW:0]   num_valid;
    logic [N-1:0]  issue, ex_start, ex_comp, write, commit;
    logic          rd_req;
    logic [IW-1:0] rd_idx;
    logic [2:0]    rd_stage;
    logic          rd_valid;
    logic [CW-1:0] rd_data;
    logic          rd_recorded;
    logic [CW-1:0] cycle_count;
    logic          all_done;
    logic          overflow;
    logic          order_error;

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];
    exp_t mon_exp;

    tomasulo_trace_recorder #(
        .NUM_INSTRUCTIONS (N),
        .NUM_CYCLES       (NC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .num_valid   (num_valid),
        .issue       (issue),
        .ex_start    (ex_start),
        .ex_comp     (ex_comp),
        .write       (write),
        .commit      (commit),
        .rd_req      (rd_req),
        .rd_idx      (rd_idx),
        .rd_stage    (rd_stage),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_recorded (rd_recorded),
        .cycle_count (cycle_count),
        .all_done    (all_done),
        .overflow    (overflow),
        .order_error (order_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every valid response must match the oldest outstanding read
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL rd_unexpected: rd_valid=1 with no outstanding read (data=%0d)", rd_data);
            end else begin
                mon_exp = sb.pop_front();
                if (rd_data !== mon_exp.data || rd_recorded !== mon_exp.rec)
                    $display("FAIL rd_resp: got data=%0d rec=%0b, want data=%0d rec=%0b",
                             rd_data, rd_recorded, mon_exp.data, mon_exp.rec);
                else
                    passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Issue one read on the next edge, leaving rd_req asserted for back-to-back use
    task automatic read_req(input int idx, input int stage, input int exp_data, input logic exp_rec);
        exp_t e;
        e.data   = CW'(exp_data);
        e.rec    = exp_rec;
        sb.push_back(e);
        rd_idx   = IW'(idx);
        rd_stage = 3'(stage);
        rd_req   = 1'b1;
        tick();
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        run       = 1'b0;
        num_valid = '0;
        issue     = '0;
        ex_start  = '0;
        ex_comp   = '0;
        write     = '0;
        commit    = '0;
        rd_req    = 1'b0;
        rd_idx    = '0;
        rd_stage  = '0;
        #2;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        rd_req = 1'b0;
        #2;
        checks++;
        if ({rd_valid, rd_data, rd_recorded, cycle_count, all_done, overflow, order_error} !== '0)
            $display("FAIL reset_outputs: got valid=%0b data=%0d rec=%0b cnt=%0d done=%0b ovf=%0b oerr=%0b, want all 0",
                     rd_valid, rd_data, rd_recorded, cycle_count, all_done, overflow, order_error);
        else passes++;
        apply_reset();
        read_req(0, 0, 0, 1'b0);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_issue_stamp();
        apply_reset();
        run = 1'b1;
        ticks(3);
        issue[0] = 1'b1;
        tick();
        run = 1'b0;
        checks++;
        if (cycle_count !== CW'(4)) $display("FAIL issue_count: got %0d want 4", cycle_count);
        else passes++;
        read_req(0, 0, 3, 1'b1);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) $display("FAIL rd_latency: rd_valid=%0b one cycle after rd_req, want 1", rd_valid);
        else passes++;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== CW'(3))
            $display("FAIL rd_hold: got valid=%0b data=%0d, want valid=0 data=3", rd_valid, rd_data);
        else passes++;
        read_req(0, 1, 0, 1'b0);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_write_once();
        apply_reset();
        run = 1'b1;
        ticks(2);
        issue[2] = 1'b1;
        tick();
        issue[2] = 1'b0;
        tick();
        ticks(5);
        checks++;
        if (cycle_count !== CW'(9)) $display("FAIL rerise_count: got %0d want 9", cycle_count);
        else passes++;
        issue[2] = 1'b1;
        tick();
        run = 1'b0;
        read_req(2, 0, 2, 1'b1);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_all_done();
        apply_reset();
        num_valid = 6'd2;
        run = 1'b1;
        ticks(5);
        commit[0] = 1'b1;
        tick();
        checks++;
        if (all_done !== 1'b0) $display("FAIL done_early: got %0b want 0", all_done);
        else passes++;
        ticks(2);
        commit[1] = 1'b1;
        tick();
        checks++;
        if (all_done !== 1'b1 || cycle_count !== CW'(9))
            $display("FAIL done_edge: got done=%0b cnt=%0d, want done=1 cnt=9", all_done, cycle_count);
        else passes++;
        issue[3] = 1'b1;
        ticks(3);
        checks++;
        if (cycle_count !== CW'(9) || all_done !== 1'b1)
            $display("FAIL done_freeze: got cnt=%0d done=%0b, want cnt=9 done=1", cycle_count, all_done);
        else passes++;
        read_req(0, 4, 5, 1'b1);
        read_req(1, 4, 8, 1'b1);
        read_req(3, 0, 0, 1'b0);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        num_valid = 6'd1;
        run = 1'b1;
        ticks(20);
        checks++;
        if (cycle_count !== CW'(NC - 1) || overflow !== 1'b1)
            $display("FAIL saturate: got cnt=%0d ovf=%0b, want cnt=%0d ovf=1", cycle_count, overflow, NC - 1);
        else passes++;
        ex_start[1] = 1'b1;
        tick();
        run = 1'b0;
        read_req(1, 1, 15, 1'b1);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        read_req(31, 2, 0, 1'b0);
        read_req(0, 6, 0, 1'b0);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run = 1'b1;
        ticks(2);
        issue[1:0]  = 2'b11;
        ex_start[0] = 1'b1;
        write[5]    = 1'b1;
        tick();
        issue[4] = 1'b1;
        read_req(4, 0, 0, 1'b0);
        run = 1'b0;
        read_req(0, 0, 2, 1'b1);
        read_req(1, 0, 2, 1'b1);
        read_req(0, 1, 2, 1'b1);
        read_req(5, 3, 2, 1'b1);
        read_req(4, 0, 3, 1'b1);
        read_req(0, 2, 0, 1'b0);
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_order();
        logic exp_err;
`ifdef TOMASULO_TRACE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        apply_reset();
        num_valid = 6'd2;
        run = 1'b1;
        tick();
        commit[1] = 1'b1;
        tick();
        checks++;
        if (order_error !== exp_err) $display("FAIL order_set: got %0b want %0b", order_error, exp_err);
        else passes++;
        commit[0] = 1'b1;
        ticks(2);
        checks++;
        if (order_error !== exp_err) $display("FAIL order_sticky: got %0b want %0b", order_error, exp_err);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_issue_stamp();
        test_write_once();
        test_all_done();
        test_saturation();
        test_out_of_range();
        test_back_to_back();
        test_order();
        ticks(2);
        checks++;
        if (sb.size() != 0) $display("FAIL rd_missing: %0d reads never answered, want 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
